// File: rtl/mem_copy_initiator.sv
// Request-side master that copies a block of words between two address ranges
// over the peripheral request/response interface, one read then one write per word.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

module mem_copy_initiator #(
    parameter int unsigned                LEN_W     = 16,
    parameter logic [`MEM_CODE_W-1:0]     CODE_OK   = `MEM_CODE_W'(0),
    parameter logic [`MEM_CODE_W-1:0]     CODE_BUSY = `MEM_CODE_W'(1),
    parameter int unsigned                MAX_RETRY = 15
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     i_start,
    input  logic [`ADDR_W-1:0]       i_src_addr,
    input  logic [`ADDR_W-1:0]       i_dst_addr,
    input  logic [LEN_W-1:0]         i_len,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic [`ADDR_W-1:0]       o_err_addr,
    output logic [LEN_W-1:0]         o_words_done,
    output logic [`ADDR_W-1:0]       o_req_addr,
    output logic [`WORD_W-1:0]       o_req_wr_data,
    output logic                     o_req_wr_en,
    output logic [`MEM_COUNT_W-1:0]  o_req_count,
    input  logic [`WORD_W-1:0]       i_res_rd_data,
    input  logic [`MEM_CODE_W-1:0]   i_res_code
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam logic [`ADDR_W-1:0]     STEP = `ADDR_W'(4);
    localparam logic [`MEM_COUNT_W-1:0] CNT4 = `MEM_COUNT_W'(4);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

    state_t               state;
    logic [`ADDR_W-1:0]   src;
    logic [`ADDR_W-1:0]   dst;
    logic [LEN_W-1:0]     len;
    logic [RW-1:0]        retry_cnt;

    // The request registers are loaded together with the state so that every
    // access is presented in the very cycle its state is entered.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            src           <= '0;
            dst           <= '0;
            len           <= '0;
            retry_cnt     <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_err_addr    <= '0;
            o_words_done  <= '0;
            o_req_addr    <= '0;
            o_req_wr_data <= '0;
            o_req_wr_en   <= 1'b0;
            o_req_count   <= '0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        src          <= {i_src_addr[`ADDR_W-1:2], 2'b00};
                        dst          <= {i_dst_addr[`ADDR_W-1:2], 2'b00};
                        len          <= i_len;
                        o_words_done <= '0;
                        o_err_addr   <= '0;
                        retry_cnt    <= '0;
                        if (i_len == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state       <= S_READ;
                            o_busy      <= 1'b1;
                            o_req_addr  <= {i_src_addr[`ADDR_W-1:2], 2'b00};
                            o_req_wr_en <= 1'b0;
                            o_req_count <= CNT4;
                        end
                    end
                end
                S_READ, S_WRITE: begin
                    if (i_res_code == CODE_OK) begin
                        retry_cnt <= '0;
                        if (state == S_READ) begin
                            state         <= S_WRITE;
                            o_req_addr    <= dst;
                            o_req_wr_data <= i_res_rd_data;
                            o_req_wr_en   <= 1'b1;
                        end else begin
                            o_words_done  <= o_words_done + LEN_W'(1);
                            src           <= src + STEP;
                            dst           <= dst + STEP;
                            o_req_wr_data <= '0;
                            o_req_wr_en   <= 1'b0;
                            if (o_words_done + LEN_W'(1) == len) begin
                                state       <= S_DONE;
                                o_done      <= 1'b1;
                                o_busy      <= 1'b0;
                                o_req_addr  <= '0;
                                o_req_count <= '0;
                            end else begin
                                state      <= S_READ;
                                o_req_addr <= src + STEP;
                            end
                        end
                    end else if (i_res_code == CODE_BUSY && retry_cnt != RW'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + RW'(1);
                    end else begin
                        // Error codes (including X/Z) and retry exhaustion both end here.
                        state         <= S_ERR;
                        o_error       <= 1'b1;
                        o_err_addr    <= o_req_addr;
                        o_busy        <= 1'b0;
                        o_req_addr    <= '0;
                        o_req_wr_data <= '0;
                        o_req_wr_en   <= 1'b0;
                        o_req_count   <= '0;
                    end
                end
                S_DONE, S_ERR: state <= S_IDLE;
                default:       state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Scoreboard bench for mem_copy_initiator: a planning model queues the expected
// request stream and outcome; a responder plays memory; a monitor checks.
`timescale 1ns/1ps
module tb_mem_copy_initiator;

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MAX_RETRY = 15;
    localparam logic [1:0]  C_OK      = 2'd0;
    localparam logic [1:0]  C_BUSY    = 2'd1;
    localparam logic [1:0]  C_BAD     = 2'd3;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              i_start = 1'b0;
    logic [31:0]       i_src_addr = '0;
    logic [31:0]       i_dst_addr = '0;
    logic [LEN_W-1:0]  i_len = '0;
    logic              o_busy, o_done, o_error;
    logic [31:0]       o_err_addr;
    logic [LEN_W-1:0]  o_words_done;
    logic [31:0]       o_req_addr, o_req_wr_data;
    logic              o_req_wr_en;
    logic [3:0]        o_req_count;
    logic [31:0]       i_res_rd_data = '0;
    logic [1:0]        i_res_code = '0;

    always #5 clk = ~clk;

    mem_copy_initiator #(
        .LEN_W(LEN_W), .CODE_OK(C_OK), .CODE_BUSY(C_BUSY), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .aresetn(aresetn), .i_start(i_start),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_err_addr(o_err_addr), .o_words_done(o_words_done),
        .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data),
        .o_req_wr_en(o_req_wr_en), .o_req_count(o_req_count),
        .i_res_rd_data(i_res_rd_data), .i_res_code(i_res_code)
    );

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } pres_t;
    typedef struct { logic err; logic [31:0] err_addr; int unsigned words; longint cyc; } out_t;

    pres_t       pres_q[$];
    out_t        out_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [logic [31:0]];
    int unsigned busy_plan[$];
    int          err_idx = -1;
    int unsigned acc_idx = 0;
    int unsigned busy_used = 0;
    int unsigned rsp_b;
    longint      cyc = 0;
    pres_t       mp;
    out_t        mo;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hD00D_0000 ^ (a * 32'd2654435761));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory/peripheral responder following the per-access busy/error plan.
    always @(posedge clk) begin
        #1;
        if (o_req_count != 0) begin
            rsp_b = (acc_idx < busy_plan.size()) ? busy_plan[acc_idx] : 0;
            if (int'(acc_idx) == err_idx) begin
                i_res_code    = C_BAD;
                i_res_rd_data = $urandom;
            end else if (busy_used < rsp_b) begin
                i_res_code    = C_BUSY;
                i_res_rd_data = $urandom;
                busy_used++;
            end else begin
                i_res_code    = C_OK;
                i_res_rd_data = o_req_wr_en ? $urandom : mem_rd(o_req_addr);
                acc_idx++;
                busy_used = 0;
            end
        end else begin
            i_res_code    = C_OK;
            i_res_rd_data = '0;
        end
    end

    // Monitor: every presented request and every completion pulse is checked.
    always @(negedge clk) begin
        if (aresetn) begin
            if (o_req_count != 0) begin
                if (pres_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %0h wr %0b expected none", o_req_addr, o_req_wr_en);
                end else begin
                    mp = pres_q.pop_front();
                    chk("req_addr", 64'(o_req_addr), 64'(mp.addr));
                    chk("req_wr_en", 64'(o_req_wr_en), 64'(mp.wr));
                    chk("req_count", 64'(o_req_count), 64'd4);
                    if (mp.wr) chk("req_wr_data", 64'(o_req_wr_data), 64'(mp.data));
                end
            end
            if (o_done || o_error) begin
                if (out_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_end: got done %0b error %0b expected none", o_done, o_error);
                end else begin
                    mo = out_q.pop_front();
                    chk("end_kind", 64'({o_error, o_done}), mo.err ? 64'd2 : 64'd1);
                    chk("words_done", 64'(o_words_done), 64'(mo.words));
                    chk("end_cycle", 64'(cyc), 64'(mo.cyc));
                    chk("busy_at_end", 64'(o_busy), 64'd0);
                    chk("count_at_end", 64'(o_req_count), 64'd0);
                    chk("leftover_reqs", 64'(pres_q.size()), 64'd0);
                    if (mo.err) chk("err_addr", 64'(o_err_addr), 64'(mo.err_addr));
                end
            end
        end
    end

    // Reference plan: word k is read from src+4k then written to dst+4k;
    // each access is presented once per BUSY plus once for its final answer.
    task automatic plan(input logic [31:0] s_in, input logic [31:0] d_in,
                        input int unsigned len, input longint start_edge);
        logic [31:0] s, d, ad, eaddr;
        int unsigned npres, words, a, b, reps;
        bit err;
        out_t o;
        pres_t p;
        s = s_in & ~32'd3;
        d = d_in & ~32'd3;
        npres = 0; words = 0; err = 0; eaddr = '0;
        for (int unsigned k = 0; k < len && !err; k++) begin
            for (int unsigned w = 0; w < 2 && !err; w++) begin
                a  = 2 * k + w;
                ad = (w != 0) ? d + 4 * k : s + 4 * k;
                b  = (a < busy_plan.size()) ? busy_plan[a] : 0;
                reps = (int'(a) == err_idx) ? 1 : (b > MAX_RETRY) ? MAX_RETRY + 1 : b + 1;
                p.addr = ad;
                p.wr   = (w != 0);
                p.data = (w != 0) ? mem_rd(s + 4 * k) : '0;
                for (int unsigned r = 0; r < reps; r++) pres_q.push_back(p);
                npres += reps;
                if (int'(a) == err_idx || b > MAX_RETRY) begin
                    err = 1; eaddr = ad;
                end else if (w != 0) begin
                    words++;
                end
            end
        end
        o.err = err; o.err_addr = eaddr; o.words = words; o.cyc = start_edge + npres;
        out_q.push_back(o);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (out_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (out_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: got no completion, expected done/error within 400 cycles");
            out_q.delete();
            pres_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int unsigned len);
        @(negedge clk);
        acc_idx = 0;
        busy_used = 0;
        plan(s, d, len, cyc + 1);
        i_src_addr = s; i_dst_addr = d; i_len = LEN_W'(len); i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_src_addr = $urandom; i_dst_addr = $urandom; i_len = LEN_W'($urandom);
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input int unsigned len, input bit poke);
        start_xfer(s, d, len);
        if (poke) begin
            @(negedge clk);
            if (o_busy) begin
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
        end
        wait_end();
    endtask

    initial begin
        int unsigned len;
        logic [31:0] s, d;
        int t;
        #1;
        chk("rst_busy", 64'(o_busy), 0);
        chk("rst_done", 64'(o_done), 0);
        chk("rst_req_count", 64'(o_req_count), 0);
        chk("rst_words_done", 64'(o_words_done), 0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;

        mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
        busy_plan = {}; err_idx = -1;
        run(32'h100, 32'h200, 3, 1'b1);
        run(32'h100, 32'h200, 0, 1'b0);
        busy_plan = '{0, 0, 0, 2};
        run(32'h100, 32'h200, 3, 1'b0);
        busy_plan = {}; err_idx = 2;
        run(32'h100, 32'h200, 3, 1'b0);
        busy_plan = '{16}; err_idx = -1;
        run(32'h100, 32'h200, 3, 1'b0);
        busy_plan = '{15}; err_idx = -1;
        run(32'h103, 32'h201, 2, 1'b0);
        busy_plan = {};
        run(32'hFFFF_FFF8, 32'hFFFF_FFFC, 4, 1'b1);

        start_xfer(32'h100, 32'h300, 3);
        t = 0;
        while (!(o_req_wr_en && o_req_addr == 32'h308) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_words", 64'(o_words_done), 64'd2);
        aresetn = 1'b0;
        #1;
        chk("arst_busy", 64'(o_busy), 0);
        chk("arst_req_addr", 64'(o_req_addr), 0);
        chk("arst_wr_data", 64'(o_req_wr_data), 0);
        chk("arst_wr_en", 64'(o_req_wr_en), 0);
        chk("arst_count", 64'(o_req_count), 0);
        chk("arst_words_done", 64'(o_words_done), 0);
        chk("arst_err_addr", 64'(o_err_addr), 0);
        chk("arst_done_error", 64'({o_done, o_error}), 0);
        pres_q.delete();
        out_q.delete();
        @(negedge clk);
        chk("arst_still_idle", 64'(o_req_count), 0);
        aresetn = 1'b1;
        run(32'h100, 32'h400, 3, 1'b0);

        for (int n = 0; n < 30; n++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            s = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
            d = $urandom;
            busy_plan = {};
            for (int unsigned a = 0; a < 2 * len; a++) begin
                if ($urandom_range(0, 29) == 0) busy_plan.push_back(16);
                else busy_plan.push_back(($urandom_range(0, 9) < 2) ? $urandom_range(1, 4) : 0);
            end
            err_idx = (len != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 * len - 1)) : -1;
            run(s, d, len, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
